// File: rtl/au_arb_pkg.sv
// ============================================================================
// Module  : au_arb_pkg
// Brief   : Shared encodings and helpers for the arithmetic-unit arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package au_arb_pkg;

   // Prefix-OR architecture selectors, shared with AU_prefix_or
   localparam int c_ARCH_SERIAL     = 0;
   localparam int c_ARCH_SKLANSKY   = 1;
   localparam int c_ARCH_BRENT_KUNG = 2;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/AU_prefix_or.sv
// ============================================================================
// Module  : AU_prefix_or
// Brief   : Upward propagate-OR: y[i] = |x[i:0], with selectable network.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module AU_prefix_or
   import au_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ARCH  = c_ARCH_SERIAL
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   localparam int c_LVLS = clog2(WIDTH);

   generate
      if (ARCH == c_ARCH_SKLANSKY) begin : g_sklansky
         logic [WIDTH-1:0] w_s;
         // Each level reads bits whose level bit is clear, so in-place update is safe
         always_comb begin
            w_s = x;
            for (int l = 0; l < c_LVLS; l++) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (((i >> l) & 1) == 1) begin
                     w_s[i] = w_s[i] | w_s[((i >> l) << l) - 1];
                  end
               end
            end
         end
         assign y = w_s;
      end else if (ARCH == c_ARCH_BRENT_KUNG) begin : g_brent_kung
         logic [WIDTH-1:0] w_s;
         always_comb begin
            w_s = x;
            for (int l = 0; l < c_LVLS; l++) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (((i + 1) % (1 << (l + 1))) == 0) begin
                     w_s[i] = w_s[i] | w_s[i - (1 << l)];
                  end
               end
            end
            for (int l = c_LVLS - 2; l >= 0; l--) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
                     w_s[i] = w_s[i] | w_s[i - (1 << l)];
                  end
               end
            end
         end
         assign y = w_s;
      end else begin : g_serial
         logic [WIDTH-1:0] w_s;
         always_comb begin
            w_s = x;
            for (int i = 1; i < WIDTH; i++) begin
               w_s[i] = w_s[i] | w_s[i-1];
            end
         end
         assign y = w_s;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/au_rr_arbiter.sv
// ============================================================================
// Module  : au_rr_arbiter
// Brief   : Round-robin arbiter with held grants and optional max-hold rotation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module au_rr_arbiter
   import au_arb_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int ARCH     = 0,
   parameter int MAX_HOLD = 0,
   localparam int c_IDX_W = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   req,
   output logic [WIDTH-1:0]   gnt,
   output logic               gnt_vld,
   output logic [c_IDX_W-1:0] gnt_idx
);

   localparam int c_CNT_W = (MAX_HOLD > 0) ? clog2(MAX_HOLD + 1) : 1;

   generate
      if ((WIDTH < 1) || (ARCH < 0) || (ARCH > 2) || (MAX_HOLD < 0)) begin : g_bad_params
         $fatal(1, "au_rr_arbiter: illegal WIDTH/ARCH/MAX_HOLD");
      end
   endgenerate

   function automatic logic [c_IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] oh);
      logic [c_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (oh[i]) idx = idx | c_IDX_W'(i);
      end
      return idx;
   endfunction

   arb_state_t         r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_gnt, w_gnt_nxt;
   logic [c_IDX_W-1:0] r_ptr, w_ptr_nxt, r_idx;
   logic               r_vld;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

   logic [WIDTH-1:0]   w_sel_v, w_ptr_oh, w_mask_po, w_mask, w_cand, w_win_po, w_win;
   logic [c_IDX_W-1:0] w_win_idx;
   logic               w_held, w_others, w_at_limit, w_take;

   // While granted the pointer equals the holder, so one selector serves both states
   assign w_sel_v  = (r_state == ST_GRANT) ? (req & ~r_gnt) : req;
   assign w_ptr_oh = WIDTH'(1) << r_ptr;

   AU_prefix_or #(.WIDTH(WIDTH), .ARCH(ARCH)) u_mask_po (
      .x (w_ptr_oh),
      .y (w_mask_po)
   );

   assign w_mask = w_mask_po << 1;
   assign w_cand = ((w_sel_v & w_mask) != '0) ? (w_sel_v & w_mask) : w_sel_v;

   AU_prefix_or #(.WIDTH(WIDTH), .ARCH(ARCH)) u_win_po (
      .x (w_cand),
      .y (w_win_po)
   );

   assign w_win      = w_win_po & ~(w_win_po << 1);
   assign w_win_idx  = onehot_to_idx(w_win);
   assign w_held     = |(req & r_gnt);
   assign w_others   = |(req & ~r_gnt);
   assign w_at_limit = (MAX_HOLD > 0) && (r_cnt == c_CNT_W'(MAX_HOLD));

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|req) w_take = 1'b1;
         end
         ST_GRANT: begin
            if (!w_held) begin
               if (|w_win) begin
                  w_take = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end else if (w_at_limit && w_others) begin
               w_take = 1'b1;
            end else if ((MAX_HOLD > 0) && !w_at_limit) begin
               w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase
      if (w_take) begin
         w_state_nxt = ST_GRANT;
         w_gnt_nxt   = w_win;
         w_ptr_nxt   = w_win_idx;
         w_cnt_nxt   = (MAX_HOLD > 0) ? c_CNT_W'(1) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_vld   <= 1'b0;
         r_idx   <= '0;
         r_ptr   <= c_IDX_W'(WIDTH - 1);
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_vld   <= |w_gnt_nxt;
         r_idx   <= onehot_to_idx(w_gnt_nxt);
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_vld = r_vld;
   assign gnt_idx = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_au_rr_arbiter.sv
// ============================================================================
// Module  : tb_au_rr_arbiter
// Brief   : Directed and randomized checks of au_rr_arbiter against a rotation model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_au_rr_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic [3:0] req4, gnt4, req4h, gnt4h;
   logic       vld4, vld4h;
   logic [1:0] idx4, idx4h;

   logic [8:0][7:0] rreq;
   logic [8:0][7:0] rgnt;
   logic [8:0][2:0] ridx;
   logic [8:0]      rvld;

   int m_w[9], m_h[9], m_vld[9], m_idx[9], m_ptr[9], m_cnt[9];
   int m_tenures[9][8];

   au_rr_arbiter #(.WIDTH(4), .ARCH(0), .MAX_HOLD(0)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .gnt_vld(vld4), .gnt_idx(idx4)
   );

   au_rr_arbiter #(.WIDTH(4), .ARCH(1), .MAX_HOLD(3)) u_dut4h (
      .clk(clk), .rst_n(rst_n), .req(req4h), .gnt(gnt4h), .gnt_vld(vld4h), .gnt_idx(idx4h)
   );

   genvar k;
   generate
      for (k = 0; k < 9; k++) begin : g_rnd
         localparam int W  = (k < 3) ? 1 : ((k < 6) ? 5 : 8);
         localparam int IW = (W > 1) ? $clog2(W) : 1;
         logic [W-1:0]  w_g;
         logic [IW-1:0] w_gi;
         au_rr_arbiter #(.WIDTH(W), .ARCH(k % 3), .MAX_HOLD(k % 3)) u_dut (
            .clk(clk), .rst_n(rst_n), .req(rreq[k][W-1:0]), .gnt(w_g),
            .gnt_vld(rvld[k]), .gnt_idx(w_gi)
         );
         assign rgnt[k] = 8'(w_g);
         assign ridx[k] = 3'(w_gi);
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // First requester strictly after p in circular order
   function automatic int model_sel(input logic [7:0] v, input int p, input int w);
      for (int s = 1; s <= w; s++) begin
         if (v[(p + s) % w]) return (p + s) % w;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < 9; j++) begin
         m_w[j]   = (j < 3) ? 1 : ((j < 6) ? 5 : 8);
         m_h[j]   = j % 3;
         m_vld[j] = 0;
         m_idx[j] = 0;
         m_ptr[j] = m_w[j] - 1;
         m_cnt[j] = 0;
         for (int i = 0; i < 8; i++) m_tenures[j][i] = 0;
      end
   endtask

   task automatic model_step(input int j, input logic [7:0] v);
      int         nw;
      logic [7:0] others;
      nw = -1;
      if (m_vld[j] == 0) begin
         if (v != 8'd0) nw = model_sel(v, m_ptr[j], m_w[j]);
      end else begin
         others = v;
         others[m_idx[j]] = 1'b0;
         if (!v[m_idx[j]]) begin
            if (others != 8'd0) nw = model_sel(others, m_idx[j], m_w[j]);
            else begin
               m_vld[j] = 0;
               m_idx[j] = 0;
               m_cnt[j] = 0;
            end
         end else if (m_h[j] > 0 && m_cnt[j] == m_h[j] && others != 8'd0) begin
            nw = model_sel(others, m_idx[j], m_w[j]);
         end else if (m_h[j] > 0 && m_cnt[j] < m_h[j]) begin
            m_cnt[j]++;
         end
      end
      if (nw >= 0) begin
         for (int i = 0; i < 8; i++) begin
            if (i >= m_w[j] || !v[i]) m_tenures[j][i] = 0;
            else if (i != nw) m_tenures[j][i]++;
         end
         m_tenures[j][nw] = 0;
         m_vld[j] = 1;
         m_idx[j] = nw;
         m_ptr[j] = nw;
         m_cnt[j] = (m_h[j] > 0) ? 1 : 0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req4  = '0;
      req4h = '0;
      rreq  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt4 !== 4'd0 || vld4 !== 1'b0 || idx4 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_dut4 cyc %0d: got gnt=%b vld=%b idx=%0d expected 0", c, gnt4, vld4, idx4);
         end
         n_checks++;
         if (gnt4h !== 4'd0 || vld4h !== 1'b0 || idx4h !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_dut4h cyc %0d: got gnt=%b vld=%b idx=%0d expected 0", c, gnt4h, vld4h, idx4h);
         end
         for (int j = 0; j < 9; j++) begin
            n_checks++;
            if (rgnt[j] !== 8'd0 || rvld[j] !== 1'b0 || ridx[j] !== 3'd0) begin
               n_fail++;
               $display("FAIL reset_rnd%0d cyc %0d: got gnt=%b vld=%b idx=%0d expected 0", j, c, rgnt[j], rvld[j], ridx[j]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      @(negedge clk);
      req4 = 4'b1111;
      for (int s = 0; s < 4; s++) begin
         exp = 4'd1 << s;
         @(negedge clk);
         n_checks++;
         if (gnt4 !== exp || idx4 !== 2'(s) || vld4 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b step %0d: got gnt=%b idx=%0d vld=%b expected gnt=%b idx=%0d", s, gnt4, idx4, vld4, exp, s);
         end
         req4 = req4 & ~exp;
      end
      @(negedge clk);
      n_checks++;
      if (gnt4 !== 4'd0 || vld4 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b idle: got gnt=%b vld=%b expected 0000 0", gnt4, vld4);
      end
   endtask

   task automatic test_hold();
      req4 = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt4 !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold cyc %0d: got gnt=%b expected 0001", c, gnt4);
         end
         if (c == 2) req4[2] = 1'b1;
      end
      req4[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (gnt4 !== 4'b0100 || idx4 !== 2'd2) begin
         n_fail++;
         $display("FAIL hold handoff: got gnt=%b idx=%0d expected 0100 2", gnt4, idx4);
      end
      req4 = 4'b1011;
      @(negedge clk);
      n_checks++;
      if (gnt4 !== 4'b1000) begin
         n_fail++;
         $display("FAIL hold ptr_after: got gnt=%b expected 1000", gnt4);
      end
      req4 = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_preempt();
      logic [3:0] exp;
      req4h = 4'b0011;
      for (int c = 0; c < 12; c++) begin
         exp = (((c / 3) % 2) == 0) ? 4'b0001 : 4'b0010;
         @(negedge clk);
         n_checks++;
         if (gnt4h !== exp || idx4h !== ((exp == 4'b0001) ? 2'd0 : 2'd1)) begin
            n_fail++;
            $display("FAIL preempt cyc %0d: got gnt=%b idx=%0d expected %b", c, gnt4h, idx4h, exp);
         end
      end
      req4h = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (gnt4h !== 4'd0) begin
         n_fail++;
         $display("FAIL preempt release: got gnt=%b expected 0000", gnt4h);
      end
      req4h = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (gnt4h !== 4'b0001) begin
            n_fail++;
            $display("FAIL preempt_alone cyc %0d: got gnt=%b expected 0001", c, gnt4h);
         end
      end
      req4h = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      req4 = 4'b0100;
      @(negedge clk);
      n_checks++;
      if (gnt4 !== 4'b0100) begin
         n_fail++;
         $display("FAIL areset setup: got gnt=%b expected 0100", gnt4);
      end
      req4 = 4'b1101;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (gnt4 !== 4'd0 || vld4 !== 1'b0 || idx4 !== 2'd0) begin
         n_fail++;
         $display("FAIL areset immediate: got gnt=%b vld=%b idx=%0d expected 0", gnt4, vld4, idx4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (gnt4 !== 4'b0001) begin
         n_fail++;
         $display("FAIL areset first_grant: got gnt=%b expected 0001", gnt4);
      end
      req4 = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] exp;
      rst_n = 1'b0;
      rreq  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int j = 0; j < 9; j++) begin
            exp = (m_vld[j] != 0) ? (8'd1 << m_idx[j]) : 8'd0;
            n_checks++;
            if (rgnt[j] !== exp) begin
               n_fail++;
               $display("FAIL rnd%0d gnt cyc %0d: got %b expected %b", j, c, rgnt[j], exp);
            end
            n_checks++;
            if (rvld[j] !== (m_vld[j] != 0) || ridx[j] !== 3'(m_idx[j])) begin
               n_fail++;
               $display("FAIL rnd%0d vld/idx cyc %0d: got %b/%0d expected %0d/%0d", j, c, rvld[j], ridx[j], m_vld[j], m_idx[j]);
            end
            n_checks++;
            if (!$onehot0(rgnt[j])) begin
               n_fail++;
               $display("FAIL rnd%0d onehot cyc %0d: got %b expected one-hot or zero", j, c, rgnt[j]);
            end
            for (int i = 0; i < m_w[j]; i++) begin
               if (!rreq[j][i]) rreq[j][i] = ($urandom_range(0, 99) < 30);
               else if (m_vld[j] != 0 && m_idx[j] == i) rreq[j][i] = ($urandom_range(0, 99) >= 35);
            end
            model_step(j, rreq[j]);
            for (int i = 0; i < m_w[j]; i++) begin
               n_checks++;
               if (m_tenures[j][i] > m_w[j] - 1) begin
                  n_fail++;
                  $display("FAIL rnd%0d fairness req %0d cyc %0d: waited %0d tenures, limit %0d", j, i, c, m_tenures[j][i], m_w[j] - 1);
               end
            end
         end
      end
      rreq = '0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_back_to_back();
      test_hold();
      test_preempt();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
